// File: rtl/regfile_pkg.sv
// Shared defaults, types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Width used to compare addresses against DEPTH independent of ADDR_W
  localparam int unsigned ADDR_CMP_W = 32;

  typedef logic [XLEN_DEF-1:0]   word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // True when addr names an implemented register (DEPTH need not be a power of 2)
  function automatic logic addr_in_range(input logic [ADDR_CMP_W-1:0] addr,
                                         input int unsigned           depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: range check, zero/bypass/storage select, registered ack/data/err.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_addr_valid,
  input  logic [DEPTH*XLEN-1:0]   mem_flat,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    wr_fwd_valid,
  output logic [XLEN-1:0]         rd_data,
  output logic                    rd_data_ack,
  output logic                    rd_err
);

  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_ack_q, rd_ack_d;
  logic            rd_err_q, rd_err_d;
  logic [XLEN-1:0] stored_c;
  logic            in_range_c;
  logic            is_zero_c;
  logic            bypass_hit_c;

  // Decode the address into the stored word; out-of-range addresses match nothing
  always_comb begin
    stored_c = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (rd_addr == ADDR_W'(j)) begin
        stored_c = mem_flat[j*XLEN +: XLEN];
      end
    end
  end

  // Classify the request: range, hard-wired zero, and same-cycle write match
  always_comb begin
    in_range_c   = addr_in_range(ADDR_CMP_W'(rd_addr), DEPTH);
    is_zero_c    = ZERO_REG && (rd_addr == '0);
    bypass_hit_c = BYPASS && wr_fwd_valid && (wr_addr == rd_addr);
  end

  // Next output values in priority order: range error, zero reg, bypass, storage
  always_comb begin
    rd_ack_d  = rd_addr_valid;
    rd_data_d = rd_data_q;
    rd_err_d  = 1'b0;
    if (rd_addr_valid) begin
      if (!in_range_c) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else if (is_zero_c) begin
        rd_data_d = '0;
      end else if (bypass_hit_c) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = stored_c;
      end
    end
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_data_ack = rd_ack_q;
  assign rd_err      = rd_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: storage, write path and NUM_RD read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_addr_valid,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_data_ack,
  output logic [NUM_RD-1:0]        rd_err,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     wr_data_valid,
  output logic                     wr_ack,
  output logic                     wr_err
);

  logic [XLEN-1:0]       mem_q [DEPTH];
  logic [XLEN-1:0]       mem_d [DEPTH];
  logic [DEPTH*XLEN-1:0] mem_flat_c;
  logic                  wr_ack_q, wr_ack_d;
  logic                  wr_err_q, wr_err_d;
  logic                  wr_in_range_c;
  logic                  wr_zero_c;
  logic                  wr_legal_c;

  // Write legality: in range and not the hard-wired zero register
  always_comb begin
    wr_in_range_c = addr_in_range(ADDR_CMP_W'(wr_addr), DEPTH);
    wr_zero_c     = ZERO_REG && (wr_addr == '0);
    wr_legal_c    = wr_data_valid && wr_in_range_c && !wr_zero_c;
  end

  // Storage next state: only a legal write changes one entry
  always_comb begin
    mem_d = mem_q;
    if (wr_legal_c) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (wr_addr == ADDR_W'(j)) begin
          mem_d[j] = wr_data;
        end
      end
    end
  end

  // Write response: every request is acked, out-of-range ones flag an error
  always_comb begin
    wr_ack_d = wr_data_valid;
    wr_err_d = wr_data_valid && !wr_in_range_c;
  end

  // Storage and write-response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Flatten storage so every read port sees the same pre-write contents
  always_comb begin
    mem_flat_c = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      mem_flat_c[j*XLEN +: XLEN] = mem_q[j];
    end
  end

  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .clk           (clk),
      .reset         (reset),
      .rd_addr       (rd_addr[i*ADDR_W +: ADDR_W]),
      .rd_addr_valid (rd_addr_valid[i]),
      .mem_flat      (mem_flat_c),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_fwd_valid  (wr_legal_c),
      .rd_data       (rd_data[i*XLEN +: XLEN]),
      .rd_data_ack   (rd_data_ack[i]),
      .rd_err        (rd_err[i])
    );
  end

endmodule
